imem_loader: RTL

Boot-time instruction-memory writer for the pipelined core. It receives a program image over a UART line, assembles little-endian 32-bit words, and writes them through the IMEM port (port A: wea/addra/dina) of the shared block RAM. It holds the core in reset while loading and releases it only after a valid image checksum. In the top level it drives port A while core_rst_n is low; the fetch stage owns the port otherwise.

---
 rtl/imem_loader_pkg.sv | 32 +++
 rtl/imem_loader_if.sv | 15 +
 rtl/imem_loader_uart_rx.sv | 85 ++++++++
 rtl/imem_loader.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time IMEM loader.
//   SYNC_BYTE    : frame start marker
//   state_t      : loader FSM states
//   rx_state_t   : UART receiver FSM states
//   clks_per_bit : clocks per UART bit, integer floor of clk_hz / baud
package loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN0 = 3'd1,
        LEN1 = 3'd2,
        DATA = 3'd3,
        CSUM = 3'd4,
        DONE = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // The receiver relies on the result being at least 4 so that the
    // half-bit start re-check and mid-bit sampling points stay distinct.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// IMEM write port (block RAM port A) as seen from the loader.
//   wea   : byte write enables, 4'hF on a word write
//   addra : word index
//   dia   : write data
// master drives the port (loader), slave observes it (RAM side / bench).
interface imem_loader_if #(
    parameter int ADDR_W = 13
) ();
    logic [3:0]        wea;
    logic [ADDR_W-1:0] addra;
    logic [31:0]       dia;

    modport master (output wea, output addra, output dia);
    modport slave  (input  wea, input  addra, input  dia);
endinterface

// File: rtl/imem_loader_uart_rx.sv
// 8N1 UART receiver.
//   clk, rst_n : clock, asynchronous active-low reset
//   rx         : serial input, idle high, asynchronous to clk
//   rx_data    : received byte, valid while rx_valid is high
//   rx_valid   : one-cycle pulse, byte received with a good stop bit
//   rx_ferr    : one-cycle pulse, stop bit sampled low
module uart_rx
    import loader_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_ferr
);

    localparam int CPB   = clks_per_bit(CLK_HZ, BAUD);
    localparam int HALF  = CPB / 2;
    localparam int CNT_W = $clog2(CPB);

    logic             rx_s1, rx_s2, rx_prev;
    rx_state_t        state, state_n;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;
    logic             bit_end, half_pt;

    assign bit_end = (clk_cnt == CNT_W'(CPB - 1));
    assign half_pt = (clk_cnt == CNT_W'(HALF - 1));
    assign rx_data = shreg;

    always_comb begin
        state_n = state;
        case (state)
            RX_IDLE:  if (rx_prev && !rx_s2) state_n = RX_START;
            // A start bit that is high again at half-bit was a glitch.
            RX_START: if (half_pt) state_n = rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (bit_end && bit_cnt == 3'd7) state_n = RX_STOP;
            RX_STOP:  if (bit_end) state_n = RX_IDLE;
            default:  state_n = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            state    <= RX_IDLE;
            clk_cnt  <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            state   <= state_n;

            // Counter restarts on every state change, so after the half-bit
            // start check each subsequent bit_end lands mid-bit.
            if (state_n != state || state == RX_IDLE || bit_end)
                clk_cnt <= '0;
            else
                clk_cnt <= clk_cnt + 1'b1;

            if (state == RX_START)
                bit_cnt <= '0;
            else if (state == RX_DATA && bit_end)
                bit_cnt <= bit_cnt + 1'b1;

            if (state == RX_DATA && bit_end)
                shreg <= {rx_s2, shreg[7:1]};

            rx_valid <= (state == RX_STOP) && bit_end && rx_s2;
            rx_ferr  <= (state == RX_STOP) && bit_end && !rx_s2;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader.
// Receives a framed program image over UART (A5, count lo, count hi,
// 4N little-endian payload bytes, 8-bit sum checksum), writes each word
// through IMEM port A and holds the core in reset until a valid checksum.
//   clk, rst_n : clock, asynchronous active-low reset
//   rx         : UART serial input
//   imem       : port A write bus (wea/addra/dia)
//   core_rst_n : core reset, released only in DONE
//   busy       : loading (LEN0/LEN1/DATA/CSUM)
//   done       : image loaded and verified
//   err        : sticky error, cleared by the next sync byte
module imem_loader
    import loader_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int BAUD         = 115200,
    parameter int ADDR_W       = 13,
    parameter int TIMEOUT_CLKS = 16 * CLK_HZ / BAUD * 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         rx,
    imem_loader_if.master imem,
    output logic         core_rst_n,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_W;
    localparam int          TMO_W     = $clog2(TIMEOUT_CLKS + 1);

    logic [7:0] rx_data;
    logic       rx_valid, rx_ferr;

    uart_rx #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_rx (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ferr  (rx_ferr)
    );

    state_t            state, state_n;
    logic [7:0]        len_lo;
    logic [15:0]       n_words;
    logic [15:0]       n_new;
    logic [7:0]        csum;
    logic [1:0]        byte_cnt;
    // One bit wider than the address so that a full 2^ADDR_W image
    // terminates without wrapping.
    logic [ADDR_W:0]   word_cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              tmo_hit, busy_st, word_last;
    logic              clr_load, set_err, take_data, wr_word;

    logic [3:0]        wea_p1;
    logic [ADDR_W-1:0] addra_p1;
    logic [31:0]       dia_p1;

    assign n_new     = {rx_data, len_lo};
    assign tmo_hit   = (tmo_cnt == TMO_W'(TIMEOUT_CLKS));
    assign busy_st   = (state == LEN0) || (state == LEN1) ||
                       (state == DATA) || (state == CSUM);
    assign word_last = (32'(word_cnt) + 32'd1) == 32'(n_words);

    always_comb begin
        state_n   = state;
        clr_load  = 1'b0;
        set_err   = 1'b0;
        take_data = 1'b0;
        wr_word   = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (rx_valid && rx_data == SYNC_BYTE) begin
                    state_n  = LEN0;
                    clr_load = 1'b1;
                end
            end
            LEN0: if (rx_valid) state_n = LEN1;
            LEN1: begin
                if (rx_valid) begin
                    if (n_new == 16'd0)
                        state_n = CSUM;
                    else if (32'(n_new) > MAX_WORDS) begin
                        state_n = IDLE;
                        set_err = 1'b1;
                    end else
                        state_n = DATA;
                end
            end
            DATA: begin
                if (rx_valid) begin
                    take_data = 1'b1;
                    if (byte_cnt == 2'd3) begin
                        wr_word = 1'b1;
                        if (word_last) state_n = CSUM;
                    end
                end
            end
            CSUM: begin
                if (rx_valid) begin
                    if (rx_data == csum)
                        state_n = DONE;
                    else begin
                        state_n = IDLE;
                        set_err = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // Framing errors and stalls only abort an active load; in IDLE and
        // DONE they are ignored.
        if (busy_st && !rx_valid && (rx_ferr || tmo_hit)) begin
            state_n = IDLE;
            set_err = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            len_lo     <= '0;
            n_words    <= '0;
            csum       <= '0;
            byte_cnt   <= '0;
            word_cnt   <= '0;
            tmo_cnt    <= '0;
            err        <= 1'b0;
            core_rst_n <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            wea_p1     <= '0;
            addra_p1   <= '0;
            dia_p1     <= '0;
        end else begin
            state <= state_n;

            if (state == LEN0 && rx_valid) len_lo  <= rx_data;
            if (state == LEN1 && rx_valid) n_words <= n_new;

            if (clr_load) begin
                csum     <= '0;
                byte_cnt <= '0;
                word_cnt <= '0;
            end else begin
                if (take_data) begin
                    csum     <= csum + rx_data;
                    byte_cnt <= byte_cnt + 1'b1;
                end
                if (wr_word) word_cnt <= word_cnt + 1'b1;
            end

            if (state_n != state || rx_valid)
                tmo_cnt <= '0;
            else if (busy_st && !tmo_hit)
                tmo_cnt <= tmo_cnt + 1'b1;

            if (clr_load)     err <= 1'b0;
            else if (set_err) err <= 1'b1;

            // ---- byte decode -> registered port A / status outputs ----
            core_rst_n <= (state_n == DONE);
            done       <= (state_n == DONE);
            busy       <= (state_n == LEN0) || (state_n == LEN1) ||
                          (state_n == DATA) || (state_n == CSUM);

            if (take_data) dia_p1[{byte_cnt, 3'b000} +: 8] <= rx_data;
            if (wr_word)   addra_p1 <= word_cnt[ADDR_W-1:0];
            wea_p1 <= wr_word ? 4'hF : 4'h0;
        end
    end

    assign imem.wea   = wea_p1;
    assign imem.addra = addra_p1;
    assign imem.dia   = dia_p1;

endmodule
